// File: rtl/network_pkg.sv
// rtl/network_pkg.sv - shared packet, result and dispatcher state types
//
// Types used by the classifier dispatcher and its packet FIFO:
//   packet_s           host packet header (src/dst ip, src/dst port, protocol)
//   dispatch_result_s  first/last rule bounds returned by the classifier
//   dispatch_state_e   dispatcher FSM states
package network_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  protocol;
    } packet_s;

    typedef struct packed {
        logic [31:0] first_src_ip;
        logic [31:0] first_dst_ip;
        logic [15:0] first_src_port;
        logic [15:0] first_dst_port;
        logic [7:0]  first_protocol;
        logic [31:0] last_src_ip;
        logic [31:0] last_dst_ip;
        logic [15:0] last_src_port;
        logic [15:0] last_dst_port;
        logic [7:0]  last_protocol;
    } dispatch_result_s;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        PRESENT
    } dispatch_state_e;

    localparam int PACKET_W = $bits(packet_s);
    localparam int RESULT_W = $bits(dispatch_result_s);

endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - small synchronous FIFO with registered head data
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, wr_data     write request (ignored while full) and data
//   pop               read request (ignored while empty)
//   rd_data           registered head entry, valid while !empty
//   full, empty       occupancy flags
module packet_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
            // The head register must track whichever entry becomes the head:
            // the incoming word when the FIFO is (or is about to be) empty,
            // otherwise the already-stored word behind the one being popped.
            if (do_push && (empty || (do_pop && count == CNT_ONE))) begin
                rd_data <= wr_data;
            end else if (do_pop && count > CNT_ONE) begin
                rd_data <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/classifier_dispatcher.sv
// rtl/classifier_dispatcher.sv - queues host packets and issues them to the classifier one at a time
//
// Optional feature macro: CLASSIFY_TIMEOUT_EN (busy watchdog aborting a stuck transaction).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready/in_packet host packet input (in_ready = FIFO not full)
//   cls_valid                   one-cycle issue pulse to the classifier
//   cls_src_ip..cls_protocol    issued packet fields, held until the next issue
//   cls_ready                   classifier ready_to_process
//   cls_first_*/cls_last_*      rule bounds returned by the classifier
//   out_valid/out_ready         result handshake
//   out_tag, out_result         sequence tag and captured bounds of the result
//   out_timeout                 result was aborted by the watchdog
module classifier_dispatcher
    import network_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PACKET_W-1:0] in_packet,
    output logic                cls_valid,
    output logic [31:0]         cls_src_ip,
    output logic [31:0]         cls_dst_ip,
    output logic [15:0]         cls_src_port,
    output logic [15:0]         cls_dst_port,
    output logic [7:0]          cls_protocol,
    input  logic                cls_ready,
    input  logic [31:0]         cls_first_src_ip,
    input  logic [31:0]         cls_first_dst_ip,
    input  logic [15:0]         cls_first_src_port,
    input  logic [15:0]         cls_first_dst_port,
    input  logic [7:0]          cls_first_protocol,
    input  logic [31:0]         cls_last_src_ip,
    input  logic [31:0]         cls_last_dst_ip,
    input  logic [15:0]         cls_last_src_port,
    input  logic [15:0]         cls_last_dst_port,
    input  logic [7:0]          cls_last_protocol,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAG_W-1:0]    out_tag,
    output logic [RESULT_W-1:0] out_result,
    output logic                out_timeout
);

    dispatch_state_e  state;
    dispatch_state_e  next_state;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [PACKET_W-1:0] fifo_head;
    packet_s          cls_pkt;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] issue_tag;
    dispatch_result_s bounds;
    logic             capture;
    logic             abort;
    logic             release_out;
    logic             timeout_hit;

    assign in_ready = !fifo_full;

    packet_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PACKET_W)
    ) u_packet_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_packet),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cls_src_ip   = cls_pkt.src_ip;
    assign cls_dst_ip   = cls_pkt.dst_ip;
    assign cls_src_port = cls_pkt.src_port;
    assign cls_dst_port = cls_pkt.dst_port;
    assign cls_protocol = cls_pkt.protocol;

    always_comb begin
        bounds                = '0;
        bounds.first_src_ip   = cls_first_src_ip;
        bounds.first_dst_ip   = cls_first_dst_ip;
        bounds.first_src_port = cls_first_src_port;
        bounds.first_dst_port = cls_first_dst_port;
        bounds.first_protocol = cls_first_protocol;
        bounds.last_src_ip    = cls_last_src_ip;
        bounds.last_dst_ip    = cls_last_dst_ip;
        bounds.last_src_port  = cls_last_src_port;
        bounds.last_dst_port  = cls_last_dst_port;
        bounds.last_protocol  = cls_last_protocol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        fifo_pop    = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                // Waiting for cls_ready also keeps a classifier that is still
                // busy after a watchdog abort from being issued a second packet.
                if (!fifo_empty && cls_ready) begin
                    fifo_pop   = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = PRESENT;
                end else if (!cls_ready) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A real completion wins over a watchdog expiring the same cycle.
                if (cls_ready) begin
                    capture    = 1'b1;
                    next_state = PRESENT;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cls_pkt    <= '0;
            cls_valid  <= 1'b0;
            tag_cnt    <= '0;
            issue_tag  <= '0;
            out_valid  <= 1'b0;
            out_tag    <= '0;
            out_result <= '0;
        end else begin
            // Pop only happens on IDLE->ISSUE, so this is the one-cycle issue pulse.
            cls_valid <= fifo_pop;
            if (fifo_pop) begin
                cls_pkt   <= fifo_head;
                issue_tag <= tag_cnt;
                tag_cnt   <= tag_cnt + TAG_W'(1);
            end
            if (capture) begin
                out_result <= bounds;
                out_tag    <= issue_tag;
                out_valid  <= 1'b1;
            end else if (abort) begin
                out_result <= '0;
                out_tag    <= issue_tag;
                out_valid  <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CLASSIFY_TIMEOUT_EN
    localparam int BUSY_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [BUSY_W-1:0] busy_cnt;

    // busy_cnt holds the number of busy cycles already elapsed, so the
    // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
    assign timeout_hit = (busy_cnt == BUSY_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt    <= '0;
            out_timeout <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                busy_cnt <= '0;
            end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
                busy_cnt <= busy_cnt + BUSY_W'(1);
            end
            if (abort) begin
                out_timeout <= 1'b1;
            end else if (release_out) begin
                out_timeout <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_classifier_dispatcher.sv
// tb/tb_classifier_dispatcher.sv - scoreboard bench for classifier_dispatcher with a behavioural classifier
module tb_classifier_dispatcher;
    import network_pkg::*;

    localparam int TAG_W = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        dispatch_result_s res;
        logic             tmo;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    packet_s             in_packet = '0;
    logic                cls_valid;
    logic [31:0]         cls_src_ip, cls_dst_ip;
    logic [15:0]         cls_src_port, cls_dst_port;
    logic [7:0]          cls_protocol;
    logic                cls_ready;
    dispatch_result_s    cls_b;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [TAG_W-1:0]    out_tag;
    logic [RESULT_W-1:0] out_result;
    logic                out_timeout;

    int checks = 0;
    int errors = 0;

    exp_t             exp_q[$];
    packet_s          pkt_q[$];
    logic [TAG_W-1:0] exp_tag = '0;
    logic             expect_tmo = 1'b0;
    logic             prev_cls = 1'b0;
    logic             saw_full = 1'b0;
    int               in_flight = 0;
    int               results = 0;

    int               busy_cnt;
    int               busy_len = 5;
    logic             cls_hold = 1'b0;

    always #5 clk = ~clk;

    classifier_dispatcher #(
        .FIFO_DEPTH     (DEPTH),
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_packet          (in_packet),
        .cls_valid          (cls_valid),
        .cls_src_ip         (cls_src_ip),
        .cls_dst_ip         (cls_dst_ip),
        .cls_src_port       (cls_src_port),
        .cls_dst_port       (cls_dst_port),
        .cls_protocol       (cls_protocol),
        .cls_ready          (cls_ready),
        .cls_first_src_ip   (cls_b.first_src_ip),
        .cls_first_dst_ip   (cls_b.first_dst_ip),
        .cls_first_src_port (cls_b.first_src_port),
        .cls_first_dst_port (cls_b.first_dst_port),
        .cls_first_protocol (cls_b.first_protocol),
        .cls_last_src_ip    (cls_b.last_src_ip),
        .cls_last_dst_ip    (cls_b.last_dst_ip),
        .cls_last_src_port  (cls_b.last_src_port),
        .cls_last_dst_port  (cls_b.last_dst_port),
        .cls_last_protocol  (cls_b.last_protocol),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_tag            (out_tag),
        .out_result         (out_result),
        .out_timeout        (out_timeout)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic dispatch_result_s bounds_of(input packet_s p);
        dispatch_result_s r;
        r.first_src_ip   = p.src_ip & 32'hFFFF_FF00;
        r.first_dst_ip   = p.dst_ip & 32'hFFFF_0000;
        r.first_src_port = p.src_port & 16'hFF00;
        r.first_dst_port = p.dst_port;
        r.first_protocol = p.protocol;
        r.last_src_ip    = p.src_ip | 32'h0000_00FF;
        r.last_dst_ip    = p.dst_ip | 32'h0000_FFFF;
        r.last_src_port  = p.src_port | 16'h00FF;
        r.last_dst_port  = p.dst_port + 16'd1;
        r.last_protocol  = ~p.protocol;
        return r;
    endfunction

    function automatic packet_s mk_pkt(input int i);
        packet_s p;
        p.src_ip   = 32'h0A00_0001 + 32'(i * 257);
        p.dst_ip   = 32'hC0A8_0100 ^ 32'(i * 40503);
        p.src_port = 16'(1024 + i * 3);
        p.dst_port = 16'(80 + i);
        p.protocol = (i % 2 == 0) ? 8'd6 : 8'd17;
        return p;
    endfunction

    // Behavioural classifier: accepts on valid&&ready, drops ready the next
    // cycle, stays busy busy_len cycles (longer while cls_hold), then raises ready.
    always @(posedge clk) begin
        if (reset) begin
            cls_ready <= 1'b1;
            busy_cnt  <= 0;
            cls_b     <= '0;
        end else if (busy_cnt > 0) begin
            if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else if (!cls_hold) begin
                busy_cnt  <= 0;
                cls_ready <= 1'b1;
            end
        end else if (cls_valid && cls_ready) begin
            cls_ready <= 1'b0;
            busy_cnt  <= busy_len;
            cls_b     <= bounds_of(packet_s'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}));
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        exp_t    e;
        packet_s p;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                pkt_q.delete();
                exp_tag   = '0;
                in_flight = 0;
                prev_cls  = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    pkt_q.push_back(in_packet);
                    e.tag = exp_tag;
                    e.res = bounds_of(in_packet);
                    e.tmo = expect_tmo;
                    exp_q.push_back(e);
                    exp_tag = exp_tag + 1'b1;
                end
                if (!in_ready) saw_full = 1'b1;
                if (cls_valid) begin
                    check("cls_pulse_width", prev_cls, 1'b0);
                    check("in_flight_at_issue", in_flight, 0);
                    if (pkt_q.size() == 0) begin
                        check("spurious_issue", 1'b1, 1'b0);
                    end else begin
                        p = pkt_q.pop_front();
                        check("cls_packet", {cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}, p);
                    end
                    in_flight++;
                end
                prev_cls = cls_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stale_result", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_tag", out_tag, e.tag);
                        check("out_result", out_result, e.tmo ? '0 : e.res);
                        check("out_timeout", out_timeout, e.tmo);
                    end
                    in_flight--;
                    results++;
                end
            end
        end
    end

    task automatic send(input packet_s p);
        int n = 0;
        in_packet = p;
        in_valid  = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("send_bound", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || pkt_q.size() != 0 || in_flight != 0 || out_valid) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_bound", n < limit, 1'b1);
    endtask

    task automatic wait_out_valid(input int limit);
        int n = 0;
        while (!out_valid && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_bound", out_valid, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int r0;
        logic [255:0] snap;

        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_cls_valid", cls_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_tag", out_tag, '0);
        check("rst_out_result", out_result, '0);
        check("rst_out_timeout", out_timeout, 1'b0);
        check("rst_cls_fields", {cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}, '0);

        // Single packet, issue latency and one result
        r0 = results;
        send(packet_s'({32'h0A00_0001, 32'h0A00_0002, 16'd5000, 16'd80, 8'd6}));
        check("issue_lat_n", cls_valid, 1'b0);
        @(posedge clk); #1;
        check("issue_lat_n1", cls_valid, 1'b1);
        wait_idle(200);
        check("single_results", results - r0, 1);

        // Burst of 6 into a 4-deep FIFO
        r0 = results;
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) send(mk_pkt(i + 1));
        check("burst_saw_full", saw_full, 1'b1);
        wait_idle(600);
        check("burst_results", results - r0, 6);

        // Backpressure on the result port
        out_ready = 1'b0;
        send(mk_pkt(20));
        send(mk_pkt(21));
        wait_out_valid(100);
        snap = {out_valid, out_tag, out_result, out_timeout};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_stable", {out_valid, out_tag, out_result, out_timeout}, snap);
            check("bp_no_issue", cls_valid, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_no_issue", cls_valid, 1'b0);
        @(posedge clk); #1;
        check("bp_next_issue", cls_valid, 1'b1);
        wait_idle(200);

        // Tag wrap with TAG_W=2 after a fresh reset: 0,1,2,3,0
        do_reset();
        r0 = results;
        for (int i = 0; i < 5; i++) send(mk_pkt(30 + i));
        wait_idle(600);
        check("wrap_results", results - r0, 5);

        // Reset while waiting for the classifier, two packets queued
        for (int i = 0; i < 3; i++) send(mk_pkt(40 + i));
        begin
            int n = 0;
            while (cls_ready && n < 100) begin @(posedge clk); #1; n++; end
            check("busy_seen", cls_ready, 1'b0);
        end
        repeat (2) begin @(posedge clk); #1; end
        r0 = results;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_cls_valid", cls_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (30) begin @(posedge clk); #1; end
        check("midrst_no_stale", results - r0, 0);
        check("midrst_idle_out", out_valid, 1'b0);

`ifdef CLASSIFY_TIMEOUT_EN
        // Watchdog abort with a classifier that never finishes
        r0 = results;
        cls_hold   = 1'b1;
        expect_tmo = 1'b1;
        send(mk_pkt(50));
        expect_tmo = 1'b0;
        wait_idle(100);
        check("tmo_results", results - r0, 1);
        send(mk_pkt(51));
        repeat (30) begin @(posedge clk); #1; end
        check("tmo_no_reissue", pkt_q.size(), 1);
        check("tmo_cls_busy", cls_ready, 1'b0);
        cls_hold = 1'b0;
        wait_idle(200);
        check("tmo_after_release", results - r0, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
